// File: rtl/tcpc_tx_arbiter.sv
// Shares the PHY transmitter between GoodCRC replies and TCPM transmissions.
// GoodCRC has strict priority; a queued TX frame is dropped when a GoodCRC request preempts it.
module tcpc_tx_arbiter #(
    parameter logic [15:0] TX_TIMEOUT = 16'd1000
) (
    input  logic        clk,
    input  logic        hard_reset,
    input  logic [7:0]  MESSAGE_HEADER_INFO,
    input  logic        rx_goodcrc_req,
    input  logic [2:0]  rx_msg_id,
    input  logic        tx_req,
    input  logic [7:0]  TX_BUF_HEADER_BYTE_0,
    input  logic [7:0]  TX_BUF_HEADER_BYTE_1,
    input  logic        phy_rx_busy,
    input  logic        phy_tx_done,
    input  logic        phy_tx_fail,
    output logic        phy_tx_start,
    output logic [15:0] phy_tx_header,
    output logic        phy_tx_goodcrc,
    output logic        GoodCRC_Transmission_Complete,
    output logic        tx_success,
    output logic        tx_discarded,
    output logic        tx_failed,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GC_WAIT = 3'd1,
        GC_SEND = 3'd2,
        TX_WAIT = 3'd3,
        TX_SEND = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        gc_pend, gc_pend_nxt;
    logic [2:0]  gc_id, gc_id_nxt;
    logic        tx_pend, tx_pend_nxt;
    logic [15:0] tx_hdr, tx_hdr_nxt;
    logic [15:0] timer, timer_nxt;

    logic        start_nxt, goodcrc_nxt, gc_done_nxt, success_nxt, discarded_nxt, failed_nxt, busy_nxt;
    logic [15:0] header_nxt;

    logic        discard, timeout, finish, launch_gc, launch_tx;
    logic [15:0] gc_header;
    logic        unused_mih;

    assign unused_mih = ^MESSAGE_HEADER_INFO[7:4];
    assign dbg_state  = state;

    // A GoodCRC request drops any TX frame that has been requested but not yet started.
    assign discard   = rx_goodcrc_req && (tx_pend || state == TX_WAIT);
    assign timeout   = (timer == TX_TIMEOUT - 16'd1);
    assign finish    = phy_tx_done || phy_tx_fail || timeout;
    assign launch_gc = (state == GC_WAIT) && !phy_rx_busy;
    assign launch_tx = (state == TX_WAIT) && !phy_rx_busy && !discard;
    assign gc_header = {4'b0000, gc_id, MESSAGE_HEADER_INFO[0], MESSAGE_HEADER_INFO[2:1],
                        MESSAGE_HEADER_INFO[3], 5'b00001};

    always_ff @(posedge clk) begin
        if (!hard_reset) begin
            state                         <= IDLE;
            gc_pend                       <= 1'b0;
            gc_id                         <= 3'd0;
            tx_pend                       <= 1'b0;
            tx_hdr                        <= 16'h0000;
            timer                         <= 16'h0000;
            phy_tx_start                  <= 1'b0;
            phy_tx_header                 <= 16'h0000;
            phy_tx_goodcrc                <= 1'b0;
            GoodCRC_Transmission_Complete <= 1'b0;
            tx_success                    <= 1'b0;
            tx_discarded                  <= 1'b0;
            tx_failed                     <= 1'b0;
            busy                          <= 1'b0;
        end else begin
            state                         <= state_nxt;
            gc_pend                       <= gc_pend_nxt;
            gc_id                         <= gc_id_nxt;
            tx_pend                       <= tx_pend_nxt;
            tx_hdr                        <= tx_hdr_nxt;
            timer                         <= timer_nxt;
            phy_tx_start                  <= start_nxt;
            phy_tx_header                 <= header_nxt;
            phy_tx_goodcrc                <= goodcrc_nxt;
            GoodCRC_Transmission_Complete <= gc_done_nxt;
            tx_success                    <= success_nxt;
            tx_discarded                  <= discarded_nxt;
            tx_failed                     <= failed_nxt;
            busy                          <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (discard || gc_pend) state_nxt = GC_WAIT;
                else if (tx_pend)       state_nxt = TX_WAIT;
            end
            GC_WAIT: if (!phy_rx_busy) state_nxt = GC_SEND;
            TX_WAIT: begin
                if (discard)           state_nxt = GC_WAIT;
                else if (!phy_rx_busy) state_nxt = TX_SEND;
            end
            GC_SEND, TX_SEND: if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gc_pend_nxt   = rx_goodcrc_req ? 1'b1 : (launch_gc ? 1'b0 : gc_pend);
        gc_id_nxt     = rx_goodcrc_req ? rx_msg_id : gc_id;
        tx_pend_nxt   = tx_req ? 1'b1 : ((discard || launch_tx) ? 1'b0 : tx_pend);
        tx_hdr_nxt    = tx_req ? {TX_BUF_HEADER_BYTE_1, TX_BUF_HEADER_BYTE_0} : tx_hdr;
        timer_nxt     = timer;
        start_nxt     = launch_gc || launch_tx;
        header_nxt    = phy_tx_header;
        goodcrc_nxt   = phy_tx_goodcrc;
        gc_done_nxt   = 1'b0;
        success_nxt   = 1'b0;
        failed_nxt    = 1'b0;
        discarded_nxt = discard;
        if (launch_gc) begin
            header_nxt  = gc_header;
            goodcrc_nxt = 1'b1;
            timer_nxt   = 16'h0000;
        end else if (launch_tx) begin
            header_nxt  = tx_hdr;
            goodcrc_nxt = 1'b0;
            timer_nxt   = 16'h0000;
        end
        if (state == GC_SEND || state == TX_SEND) begin
            if (finish) goodcrc_nxt = 1'b0;
            else        timer_nxt   = timer + 16'd1;
        end
        // Done wins over a same-cycle timeout; done together with fail counts as fail.
        if (state == GC_SEND) gc_done_nxt = phy_tx_done || phy_tx_fail;
        if (state == TX_SEND) begin
            success_nxt = phy_tx_done && !phy_tx_fail;
            failed_nxt  = phy_tx_fail || (timeout && !phy_tx_done);
        end
        busy_nxt = (state_nxt != IDLE) || gc_pend_nxt || tx_pend_nxt;
    end

endmodule

// File: tb/tb_tcpc_tx_arbiter.sv
// Directed bench for tcpc_tx_arbiter: GoodCRC, TX, discard, back-to-back, timeout, reset.
module tb_tcpc_tx_arbiter;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GC_WAIT = 3'd1;
    localparam logic [2:0] S_GC_SEND = 3'd2;
    localparam logic [2:0] S_TX_WAIT = 3'd3;

    logic        clk = 1'b0;
    logic        hard_reset;
    logic [7:0]  MESSAGE_HEADER_INFO;
    logic        rx_goodcrc_req;
    logic [2:0]  rx_msg_id;
    logic        tx_req;
    logic [7:0]  TX_BUF_HEADER_BYTE_0;
    logic [7:0]  TX_BUF_HEADER_BYTE_1;
    logic        phy_rx_busy;
    logic        phy_tx_done;
    logic        phy_tx_fail;
    logic        phy_tx_start;
    logic [15:0] phy_tx_header;
    logic        phy_tx_goodcrc;
    logic        GoodCRC_Transmission_Complete;
    logic        tx_success;
    logic        tx_discarded;
    logic        tx_failed;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    tcpc_tx_arbiter #(.TX_TIMEOUT(16'd16)) dut (
        .clk(clk), .hard_reset(hard_reset), .MESSAGE_HEADER_INFO(MESSAGE_HEADER_INFO),
        .rx_goodcrc_req(rx_goodcrc_req), .rx_msg_id(rx_msg_id), .tx_req(tx_req),
        .TX_BUF_HEADER_BYTE_0(TX_BUF_HEADER_BYTE_0), .TX_BUF_HEADER_BYTE_1(TX_BUF_HEADER_BYTE_1),
        .phy_rx_busy(phy_rx_busy), .phy_tx_done(phy_tx_done), .phy_tx_fail(phy_tx_fail),
        .phy_tx_start(phy_tx_start), .phy_tx_header(phy_tx_header), .phy_tx_goodcrc(phy_tx_goodcrc),
        .GoodCRC_Transmission_Complete(GoodCRC_Transmission_Complete), .tx_success(tx_success),
        .tx_discarded(tx_discarded), .tx_failed(tx_failed), .busy(busy), .dbg_state(dbg_state)
    );

    // Clock and reset: inputs change and outputs are sampled on the falling edge.
    always #5 clk = ~clk;

    initial begin
        hard_reset = 1'b0;
        MESSAGE_HEADER_INFO = 8'h00;
        rx_goodcrc_req = 1'b0;
        rx_msg_id = 3'd0;
        tx_req = 1'b0;
        TX_BUF_HEADER_BYTE_0 = 8'h00;
        TX_BUF_HEADER_BYTE_1 = 8'h00;
        phy_rx_busy = 1'b0;
        phy_tx_done = 1'b0;
        phy_tx_fail = 1'b0;
    end

    task automatic test_reset;
        hard_reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (phy_tx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", phy_tx_start); end
        n_checks++; if (phy_tx_header !== 16'h0000) begin n_fail++; $display("FAIL reset_header: got %h want 0000", phy_tx_header); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        n_checks++; if ({GoodCRC_Transmission_Complete, tx_success, tx_discarded, tx_failed, phy_tx_goodcrc} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b want 00000",
                {GoodCRC_Transmission_Complete, tx_success, tx_discarded, tx_failed, phy_tx_goodcrc}); end
        hard_reset = 1'b1;
        @(negedge clk);
    endtask

    // MIH 8'b00011010 -> [5]=1, [7:6]=01, [8]=0; id 5 -> 0xA00; total 16'h0A61.
    // MIH 8'h04 -> [7:6]=10, others 0; id 5 -> 16'h0A81. The second frame completes via phy_tx_fail.
    task automatic test_goodcrc;
        logic [7:0]  mih [2];
        logic [15:0] exp_hdr;
        mih[0] = 8'b00011010;
        mih[1] = 8'h04;
        exp_q.push_back(16'h0A61);
        exp_q.push_back(16'h0A81);
        for (int i = 0; i < 2; i++) begin
            MESSAGE_HEADER_INFO = mih[i];
            rx_msg_id = 3'd5;
            rx_goodcrc_req = 1'b1;
            @(negedge clk);
            rx_goodcrc_req = 1'b0;
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gc_busy[%0d]: got %b want 1", i, busy); end
            @(negedge clk);
            n_checks++; if (dbg_state !== S_GC_WAIT || phy_tx_start !== 1'b0) begin n_fail++;
                $display("FAIL gc_wait[%0d]: state %0d start %b want 1/0", i, dbg_state, phy_tx_start); end
            @(negedge clk);
            exp_hdr = exp_q.pop_front();
            n_checks++; if (phy_tx_start !== 1'b1) begin n_fail++; $display("FAIL gc_start[%0d]: got %b want 1", i, phy_tx_start); end
            n_checks++; if (phy_tx_header !== exp_hdr) begin n_fail++; $display("FAIL gc_header[%0d]: got %h want %h", i, phy_tx_header, exp_hdr); end
            n_checks++; if (phy_tx_goodcrc !== 1'b1) begin n_fail++; $display("FAIL gc_flag[%0d]: got %b want 1", i, phy_tx_goodcrc); end
            @(negedge clk);
            n_checks++; if (phy_tx_start !== 1'b0 || phy_tx_header !== exp_hdr) begin n_fail++;
                $display("FAIL gc_hold[%0d]: start %b header %h want 0/%h", i, phy_tx_start, phy_tx_header, exp_hdr); end
            if (i == 0) phy_tx_done = 1'b1; else phy_tx_fail = 1'b1;
            @(negedge clk);
            phy_tx_done = 1'b0;
            phy_tx_fail = 1'b0;
            n_checks++; if (GoodCRC_Transmission_Complete !== 1'b1 || dbg_state !== S_IDLE || busy !== 1'b0) begin n_fail++;
                $display("FAIL gc_complete[%0d]: pulse %b state %0d busy %b want 1/0/0", i,
                    GoodCRC_Transmission_Complete, dbg_state, busy); end
            @(negedge clk);
            n_checks++; if (GoodCRC_Transmission_Complete !== 1'b0) begin n_fail++; $display("FAIL gc_pulse_len[%0d]: got %b want 0", i, GoodCRC_Transmission_Complete); end
        end
    endtask

    task automatic test_tx;
        for (int i = 0; i < 2; i++) begin
            TX_BUF_HEADER_BYTE_0 = 8'h4B;
            TX_BUF_HEADER_BYTE_1 = 8'h27;
            tx_req = 1'b1;
            @(negedge clk);
            tx_req = 1'b0;
            TX_BUF_HEADER_BYTE_0 = 8'h00;
            TX_BUF_HEADER_BYTE_1 = 8'h00;
            @(negedge clk);
            n_checks++; if (dbg_state !== S_TX_WAIT) begin n_fail++; $display("FAIL tx_wait[%0d]: got %0d want 3", i, dbg_state); end
            @(negedge clk);
            n_checks++; if (phy_tx_start !== 1'b1 || phy_tx_header !== 16'h274B || phy_tx_goodcrc !== 1'b0) begin n_fail++;
                $display("FAIL tx_start[%0d]: start %b header %h gc %b want 1/274B/0", i, phy_tx_start, phy_tx_header, phy_tx_goodcrc); end
            if (i == 0) phy_tx_done = 1'b1; else phy_tx_fail = 1'b1;
            @(negedge clk);
            phy_tx_done = 1'b0;
            phy_tx_fail = 1'b0;
            if (i == 0) begin
                n_checks++; if (tx_success !== 1'b1 || tx_failed !== 1'b0) begin n_fail++;
                    $display("FAIL tx_success: success %b failed %b want 1/0", tx_success, tx_failed); end
            end else begin
                n_checks++; if (tx_failed !== 1'b1 || tx_success !== 1'b0) begin n_fail++;
                    $display("FAIL tx_failed: success %b failed %b want 0/1", tx_success, tx_failed); end
            end
            @(negedge clk);
            n_checks++; if (tx_success !== 1'b0 || tx_failed !== 1'b0 || busy !== 1'b0) begin n_fail++;
                $display("FAIL tx_after[%0d]: success %b failed %b busy %b want 0/0/0", i, tx_success, tx_failed, busy); end
        end
    endtask

    // MIH 8'h04 with id 2: 0x001 | 0x080 | 0x400 = 16'h0481.
    task automatic test_discard;
        int starts = 0;
        MESSAGE_HEADER_INFO = 8'h04;
        phy_rx_busy = 1'b1;
        TX_BUF_HEADER_BYTE_0 = 8'h11;
        TX_BUF_HEADER_BYTE_1 = 8'h22;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (dbg_state !== S_TX_WAIT || phy_tx_start !== 1'b0) begin n_fail++;
            $display("FAIL disc_hold: state %0d start %b want 3/0", dbg_state, phy_tx_start); end
        rx_msg_id = 3'd2;
        rx_goodcrc_req = 1'b1;
        @(negedge clk);
        rx_goodcrc_req = 1'b0;
        n_checks++; if (tx_discarded !== 1'b1 || dbg_state !== S_GC_WAIT) begin n_fail++;
            $display("FAIL disc_pulse: discarded %b state %0d want 1/1", tx_discarded, dbg_state); end
        @(negedge clk);
        n_checks++; if (tx_discarded !== 1'b0) begin n_fail++; $display("FAIL disc_len: got %b want 0", tx_discarded); end
        phy_rx_busy = 1'b0;
        @(negedge clk);
        n_checks++; if (phy_tx_start !== 1'b1 || phy_tx_goodcrc !== 1'b1 || phy_tx_header !== 16'h0481) begin n_fail++;
            $display("FAIL disc_gc_start: start %b gc %b header %h want 1/1/0481", phy_tx_start, phy_tx_goodcrc, phy_tx_header); end
        phy_tx_done = 1'b1;
        @(negedge clk);
        phy_tx_done = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (phy_tx_start === 1'b1) starts++;
            @(negedge clk);
        end
        n_checks++; if (starts != 0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL disc_no_tx: starts %0d busy %b want 0/0", starts, busy); end
    endtask

    // MIH 8'h04 with id 3: 0x001 | 0x080 | 0x600 = 16'h0681.
    task automatic test_back_to_back;
        MESSAGE_HEADER_INFO = 8'h04;
        TX_BUF_HEADER_BYTE_0 = 8'hA5;
        TX_BUF_HEADER_BYTE_1 = 8'h5A;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (phy_tx_start !== 1'b1 || phy_tx_header !== 16'h5AA5) begin n_fail++;
            $display("FAIL b2b_tx_start: start %b header %h want 1/5AA5", phy_tx_start, phy_tx_header); end
        rx_msg_id = 3'd3;
        rx_goodcrc_req = 1'b1;
        @(negedge clk);
        rx_goodcrc_req = 1'b0;
        n_checks++; if (tx_discarded !== 1'b0) begin n_fail++; $display("FAIL b2b_no_discard: got %b want 0", tx_discarded); end
        phy_tx_done = 1'b1;
        @(negedge clk);
        phy_tx_done = 1'b0;
        n_checks++; if (tx_success !== 1'b1 || dbg_state !== S_IDLE || busy !== 1'b1) begin n_fail++;
            $display("FAIL b2b_tx_done: success %b state %0d busy %b want 1/0/1", tx_success, dbg_state, busy); end
        @(negedge clk);
        n_checks++; if (phy_tx_start !== 1'b0 || dbg_state !== S_GC_WAIT) begin n_fail++;
            $display("FAIL b2b_gap: start %b state %0d want 0/1", phy_tx_start, dbg_state); end
        @(negedge clk);
        n_checks++; if (phy_tx_start !== 1'b1 || phy_tx_goodcrc !== 1'b1 || phy_tx_header !== 16'h0681) begin n_fail++;
            $display("FAIL b2b_gc_start: start %b gc %b header %h want 1/1/0681", phy_tx_start, phy_tx_goodcrc, phy_tx_header); end
        phy_tx_done = 1'b1;
        @(negedge clk);
        phy_tx_done = 1'b0;
        n_checks++; if (GoodCRC_Transmission_Complete !== 1'b1 || tx_success !== 1'b0) begin n_fail++;
            $display("FAIL b2b_gc_done: complete %b success %b want 1/0", GoodCRC_Transmission_Complete, tx_success); end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        int early = 0;
        TX_BUF_HEADER_BYTE_0 = 8'h01;
        TX_BUF_HEADER_BYTE_1 = 8'h02;
        tx_req = 1'b1;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (phy_tx_start !== 1'b1) begin n_fail++; $display("FAIL to_start: got %b want 1", phy_tx_start); end
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (tx_failed === 1'b1) early++;
        end
        n_checks++; if (early != 0) begin n_fail++; $display("FAIL to_early: %0d early pulses want 0", early); end
        @(negedge clk);
        n_checks++; if (tx_failed !== 1'b1 || dbg_state !== S_IDLE || busy !== 1'b0) begin n_fail++;
            $display("FAIL to_fail: failed %b state %0d busy %b want 1/0/0", tx_failed, dbg_state, busy); end
        @(negedge clk);
        n_checks++; if (tx_failed !== 1'b0) begin n_fail++; $display("FAIL to_len: got %b want 0", tx_failed); end
    endtask

    task automatic test_reset_midframe;
        MESSAGE_HEADER_INFO = 8'h04;
        rx_msg_id = 3'd1;
        rx_goodcrc_req = 1'b1;
        @(negedge clk);
        rx_goodcrc_req = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (dbg_state !== S_GC_SEND) begin n_fail++; $display("FAIL rst_pre: state %0d want 2", dbg_state); end
        hard_reset = 1'b0;
        @(negedge clk);
        hard_reset = 1'b1;
        n_checks++; if ({phy_tx_start, phy_tx_goodcrc, busy, GoodCRC_Transmission_Complete} !== 4'b0 ||
                        phy_tx_header !== 16'h0000 || dbg_state !== S_IDLE) begin n_fail++;
            $display("FAIL rst_mid: start %b gc %b busy %b cmp %b header %h state %0d want all 0", phy_tx_start,
                phy_tx_goodcrc, busy, GoodCRC_Transmission_Complete, phy_tx_header, dbg_state); end
        phy_tx_done = 1'b1;
        @(negedge clk);
        phy_tx_done = 1'b0;
        n_checks++; if (GoodCRC_Transmission_Complete !== 1'b0 || tx_success !== 1'b0) begin n_fail++;
            $display("FAIL rst_no_pulse: complete %b success %b want 0/0", GoodCRC_Transmission_Complete, tx_success); end
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_goodcrc();
        test_tx();
        test_discard();
        test_back_to_back();
        test_timeout();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
